fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 23 ++
 rtl/fetch_unit_out_buf.sv | 38 +++
 rtl/fetch_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared state encoding, constants and address helpers for the instruction fetch unit.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_e;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned BUF_W            = 64;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_unit_out_buf.sv
// One-entry output buffer holding {pc, instruction} for decode.
module fetch_out_buf
    import fetch_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic             consume,
    input  logic [BUF_W-1:0] load_data,
    output logic             valid,
    output logic [BUF_W-1:0] data
);

    logic             valid_r;
    logic [BUF_W-1:0] data_r;

    // Buffer occupancy and payload; a redirect clear outranks a load, a load outranks a consume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= {BUF_W{1'b0}};
        end else if (clear) begin
            valid_r <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= load_data;
        end else if (consume) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign valid = valid_r;
    assign data  = data_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single outstanding request, redirect handling, one-entry output buffer.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        take_branch,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready,
    output logic        misaligned_err
);

    fetch_state_e     state_r;
    logic [31:0]      pc_r;
    logic             mis_err_r;

    logic             redirect_s;
    logic [31:0]      tgt_s;
    logic             consume_s;
    logic             load_s;
    logic             buf_valid_s;
    logic [BUF_W-1:0] buf_data_s;

    // Redirect selection: a resolved branch outranks a jump.
    always_comb begin
        redirect_s = take_branch | jump;
        if (take_branch) begin
            tgt_s = branch_target;
        end else begin
            tgt_s = jump_target;
        end
    end

    // Buffer handshakes; a response arriving with a redirect is stale and never loaded.
    always_comb begin
        consume_s = buf_valid_s & if_ready;
        if ((state_r == ST_WAIT) && imem_rsp_valid && !redirect_s) begin
            load_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end
    end

    // Fetch sequencer: state, pc and the misalignment pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            pc_r      <= RESET_PC;
            mis_err_r <= 1'b0;
        end else if (redirect_s) begin
            pc_r      <= word_align(tgt_s);
            mis_err_r <= is_misaligned(tgt_s);
            // An accepted but unanswered request must be drained in DROP before reissuing.
            case (state_r)
                ST_IDLE: state_r <= ST_REQ;
                ST_REQ: begin
                    if (imem_req_ready) state_r <= ST_DROP;
                    else                state_r <= ST_REQ;
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) state_r <= ST_REQ;
                    else                state_r <= ST_DROP;
                end
                ST_DROP: begin
                    if (imem_rsp_valid) state_r <= ST_REQ;
                    else                state_r <= ST_DROP;
                end
                default: state_r <= ST_IDLE;
            endcase
        end else begin
            mis_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (!buf_valid_s || consume_s) state_r <= ST_REQ;
                    else                           state_r <= ST_IDLE;
                end
                ST_REQ: begin
                    if (imem_req_ready) state_r <= ST_WAIT;
                    else                state_r <= ST_REQ;
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        state_r <= ST_IDLE;
                        pc_r    <= pc_r + PC_STEP;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_DROP: begin
                    if (imem_rsp_valid) state_r <= ST_REQ;
                    else                state_r <= ST_DROP;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    fetch_out_buf u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .clear     (redirect_s),
        .consume   (consume_s),
        .load_data ({pc_r, imem_rsp_data}),
        .valid     (buf_valid_s),
        .data      (buf_data_s)
    );

    assign imem_req_valid = (state_r == ST_REQ);
    assign imem_req_addr  = pc_r;
    assign if_valid       = buf_valid_s;
    assign if_instr       = buf_data_s[31:0];
    assign if_pc          = buf_data_s[63:32];
    assign misaligned_err = mis_err_r;

endmodule
